dice_roller: RTL and testbench

//   Multi-die roller: rolls num_dice dice of a selectable size and returns each face plus the running sum.

---
 rtl/dice_roller.sv | 136 +++++++++++++
 tb/tb_dice_roller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roller.sv
// dice_roller: rolls up to MAX_DICE dice, faces drawn from a free-running 16-bit LFSR by rejection sampling.
// Build option: define SEED_LOAD_EN to add seed_load/seed_in for reseeding the LFSR while idle.
module dice_roller #(
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          MAX_DICE = 8,
  localparam int         CNT_W    = $clog2(MAX_DICE + 1),
  localparam int         SUM_W    = $clog2(MAX_DICE * 100 + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       die_sel,
  input  logic [CNT_W-1:0] num_dice,
`ifdef SEED_LOAD_EN
  input  logic             seed_load,
  input  logic [15:0]      seed_in,
`endif
  output logic             busy,
  output logic [6:0]       face,
  output logic             face_valid,
  output logic [SUM_W-1:0] sum,
  output logic             done
);
  localparam logic [15:0]      SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_DICE);

  typedef enum logic [1:0] {IDLE, ROLL, DONE} state_e;

  function automatic logic [6:0] sides_f(input logic [2:0] d);
    case (d)
      3'd0:    sides_f = 7'd4;
      3'd1:    sides_f = 7'd6;
      3'd2:    sides_f = 7'd8;
      3'd3:    sides_f = 7'd10;
      3'd4:    sides_f = 7'd12;
      3'd5:    sides_f = 7'd20;
      3'd6:    sides_f = 7'd100;
      default: sides_f = 7'd2;
    endcase
  endfunction

  // Smallest all-ones mask covering 0..sides-1, so the accept rate stays at or above 1/2.
  function automatic logic [6:0] mask_f(input logic [2:0] d);
    case (d)
      3'd0:          mask_f = 7'd3;
      3'd1, 3'd2:    mask_f = 7'd7;
      3'd3, 3'd4:    mask_f = 7'd15;
      3'd5:          mask_f = 7'd31;
      3'd6:          mask_f = 7'd127;
      default:       mask_f = 7'd1;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [2:0]       die_q, die_d;
  logic [CNT_W-1:0] n_q, n_d, cnt_q, cnt_d, n_eff;
  logic [6:0]       face_q, face_d, raw;
  logic             fv_q, fv_d, accept;
  logic [SUM_W-1:0] sum_q, sum_d;

  always_comb begin
    if (num_dice == '0)          n_eff = CNT_W'(1);
    else if (num_dice > MAX_CNT) n_eff = MAX_CNT;
    else                         n_eff = num_dice;
  end

  assign raw    = lfsr_q[6:0] & mask_f(die_q);
  assign accept = (raw < sides_f(die_q));

  always_comb begin
    state_d = state_q;
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    die_d   = die_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    face_d  = face_q;
    fv_d    = 1'b0;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          die_d   = die_sel;
          n_d     = n_eff;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = ROLL;
        end
`ifdef SEED_LOAD_EN
        else if (seed_load) begin
          lfsr_d = (seed_in == 16'h0000) ? 16'h0001 : seed_in;
        end
`endif
      end
      ROLL: begin
        if (accept) begin
          face_d = raw + 7'd1;
          fv_d   = 1'b1;
          sum_d  = sum_q + SUM_W'(raw) + SUM_W'(1);
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == n_q) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_EFF;
      die_q   <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      face_q  <= '0;
      fv_q    <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      die_q   <= die_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      face_q  <= face_d;
      fv_q    <= fv_d;
      sum_q   <= sum_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign face       = face_q;
  assign face_valid = fv_q;
  assign sum        = sum_q;

endmodule

// File: tb/tb_dice_roller.sv
// Bench for dice_roller: a reference LFSR predicts every face, sum and latency into scoreboard queues.
module tb_dice_roller;
  localparam int MAX_DICE = 8;
  localparam int CNT_W    = $clog2(MAX_DICE + 1);
  localparam int SUM_W    = $clog2(MAX_DICE * 100 + 1);

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       die_sel = 3'd0;
  logic [CNT_W-1:0] num_dice = '0;
`ifdef SEED_LOAD_EN
  logic             seed_load = 1'b0;
  logic [15:0]      seed_in = 16'h0000;
`endif
  logic             busy, face_valid, done;
  logic [6:0]       face;
  logic [SUM_W-1:0] sum;

  int n_cmp = 0;
  int n_bad = 0;
  int fv_cnt = 0;
  int last_sum = 0;
  int hist [128];
  logic [15:0]      m_lfsr;
  logic [6:0]       exp_face_q [$];
  logic [SUM_W-1:0] exp_sum_q [$];
  logic [6:0]       seq_q [$];
  logic [6:0]       mon_ef;
  logic [SUM_W-1:0] mon_es;

  dice_roller #(.MAX_DICE(MAX_DICE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .die_sel(die_sel), .num_dice(num_dice),
`ifdef SEED_LOAD_EN
    .seed_load(seed_load), .seed_in(seed_in),
`endif
    .busy(busy), .face(face), .face_valid(face_valid), .sum(sum), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int sides_of(input logic [2:0] d);
    int t [8] = '{4, 6, 8, 10, 12, 20, 100, 2};
    return t[d];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference LFSR, kept in lockstep with the DUT's free-running generator.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
`ifdef SEED_LOAD_EN
    else if (seed_load && !start) m_lfsr <= (seed_in == 16'h0000) ? 16'h0001 : seed_in;
`endif
    else m_lfsr <= lfsr_next(m_lfsr);
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (face_valid) begin
        fv_cnt++;
        hist[face]++;
        seq_q.push_back(face);
        if (exp_face_q.size() == 0) check("unexpected_face", face_valid, 1'b0);
        else begin
          mon_ef = exp_face_q.pop_front();
          check("face", face, mon_ef);
        end
      end
      if (done) begin
        if (exp_sum_q.size() == 0) check("unexpected_done", done, 1'b0);
        else begin
          mon_es = exp_sum_q.pop_front();
          check("sum", sum, mon_es);
        end
      end
    end
  end

  task automatic launch(input logic [2:0] d, input int n, output int exp_lat, output int neff);
    int sides, mask, acc, cyc, tot, raw;
    logic [15:0] l;
    sides = sides_of(d);
    mask = 1;
    while (mask < sides - 1) mask = mask * 2 + 1;
    neff = (n == 0) ? 1 : ((n > MAX_DICE) ? MAX_DICE : n);
    @(posedge clk); #1;
    start = 1'b1; die_sel = d; num_dice = CNT_W'(n);
    fv_cnt = 0;
    l = m_lfsr; acc = 0; cyc = 0; tot = 0;
    while (acc < neff) begin
      l = lfsr_next(l);
      cyc++;
      raw = int'(l[6:0]) & mask;
      if (raw < sides) begin
        exp_face_q.push_back(7'(raw + 1));
        tot += raw + 1;
        acc++;
      end
    end
    exp_sum_q.push_back(SUM_W'(tot));
    last_sum = tot;
    exp_lat = cyc + 1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic roll(input logic [2:0] d, input int n, input int poke, output int lat);
    int exp_lat, neff;
    launch(d, n, exp_lat, neff);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("busy_after_start", busy, 1'b1);
      if (poke != 0 && lat == poke) begin
        start = 1'b1; die_sel = 3'd7; num_dice = CNT_W'(1);
      end else start = 1'b0;
    end while (!done && lat < 400);
    start = 1'b0;
    check("done_seen", done, 1'b1);
    check("latency", lat, exp_lat);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("busy_low_after_done", busy, 1'b0);
    check("face_count", fv_cnt, neff);
    check("queue_drained", exp_face_q.size(), 0);
    check("sum_held", sum, last_sum);
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 128; i++) hist[i] = 0;
  endtask

  initial begin
    int lat, el, en, outside, maxlat;
`ifdef SEED_LOAD_EN
    logic [6:0] run0 [$];
`endif
    clear_hist();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_sum", sum, 0);
    check("rst_done", done, 1'b0);
    check("rst_face_valid", face_valid, 1'b0);
    check("rst_face", face, 0);
    check("rst_lfsr", dut.lfsr_q, 16'hACE1);
    @(posedge clk); #1 reset_n = 1'b1;

    roll(3'd5, 1, 0, lat);
    check("d20_face_range", (face >= 7'd1) && (face <= 7'd20), 1'b1);
    check("d20_sum_eq_face", sum, face);

    for (int d = 0; d < 8; d++) roll(3'(d), 3, 0, lat);
    roll(3'd2, 0, 0, lat);
    roll(3'd4, 15, 0, lat);
    roll(3'd6, MAX_DICE, 0, lat);

    clear_hist();
    for (int i = 0; i < 2000; i++) roll(3'd1, 1, 0, lat);
    outside = hist[0];
    for (int k = 7; k < 128; k++) outside += hist[k];
    check("d6_outside_1_6", outside, 0);
    for (int k = 1; k <= 6; k++) check($sformatf("d6_face%0d_min200", k), hist[k] >= 200, 1'b1);

    clear_hist();
    maxlat = 0;
    for (int i = 0; i < 60; i++) begin
      roll(3'd6, 1, 0, lat);
      if (lat > maxlat) maxlat = lat;
    end
    outside = hist[0];
    for (int k = 101; k < 128; k++) outside += hist[k];
    check("d100_outside_1_100", outside, 0);
    $display("info: d100 max latency %0d cycles", maxlat);

    roll(3'd6, 8, 2, lat);

    launch(3'd5, 8, el, en);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    exp_face_q.delete();
    exp_sum_q.delete();
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_sum", sum, 0);
    check("abort_face", face, 0);
    check("abort_done", done, 1'b0);
    check("abort_lfsr", dut.lfsr_q, 16'hACE1);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_abort_idle", busy, 1'b0);
    roll(3'd3, 4, 0, lat);

`ifdef SEED_LOAD_EN
    for (int rep = 0; rep < 2; rep++) begin
      @(posedge clk); #1 seed_load = 1'b1; seed_in = 16'h1234;
      @(posedge clk); #1 seed_load = 1'b0;
      seq_q.delete();
      for (int i = 0; i < 10; i++) roll(3'd5, 1, 0, lat);
      if (rep == 0) run0 = seq_q;
    end
    check("seed_seq_len", seq_q.size(), 10);
    for (int i = 0; i < 10 && i < seq_q.size() && i < run0.size(); i++)
      check($sformatf("seed_seq_%0d", i), seq_q[i], run0[i]);
    @(posedge clk); #1 seed_load = 1'b1; seed_in = 16'h0000;
    @(posedge clk); #1 seed_load = 1'b0;
    check("seed_zero_lfsr", dut.lfsr_q, 16'h0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
